// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP batch sequencer: default widths, watchdog
// limit and the FSM state encoding.
package mlp_pkg;

  localparam int IDX_W       = 10;
  localparam int CLS_W       = 10;
  localparam int TIMEOUT_DEF = 1023;
  localparam int STATE_W     = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_LAUNCH  = 3'd1;
  localparam state_t S_WAIT    = 3'd2;
  localparam state_t S_CAPTURE = 3'd3;
  localparam state_t S_FIN     = 3'd4;
  localparam state_t S_ERR     = 3'd5;

  // True for the states in which a batch is in flight (drives busy).
  function automatic logic is_active(input state_t s);
    return (s == S_LAUNCH) || (s == S_WAIT) || (s == S_CAPTURE);
  endfunction

endpackage

// File: rtl/mlp_watchdog.sv
// Cycle counter guarding the wait for mlp_done. Cleared by clr, counts while
// en is high, and flags when the count has reached TIMEOUT.
module mlp_watchdog #(
  parameter int TIMEOUT = mlp_pkg::TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int              WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] TC_VAL = WD_W'(TIMEOUT);

  logic [WD_W-1:0] cnt_r;
  logic [WD_W-1:0] cnt_s;
  logic            tc_r;

  // Next count: clear has priority over counting.
  always_comb begin
    cnt_s = cnt_r;
    if (clr) begin
      cnt_s = {WD_W{1'b0}};
    end else if (en) begin
      cnt_s = cnt_r + WD_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Counter and registered terminal-count flag (tracks cnt_r == TIMEOUT).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {WD_W{1'b0}};
      tc_r  <= 1'b0;
    end else begin
      cnt_r <= cnt_s;
      tc_r  <= (cnt_s == TC_VAL);
    end
  end

  assign tc = tc_r;

endmodule

// File: rtl/mlp_batch_sequencer.sv
// Walks the MLP core over a contiguous range of sample indices, captures the
// predicted class per sample, scores it against the label ROM and streams one
// result per sample while keeping a running correct count.
module mlp_batch_sequencer #(
  parameter int IDX_W   = mlp_pkg::IDX_W,
  parameter int CLS_W   = mlp_pkg::CLS_W,
  parameter int TIMEOUT = mlp_pkg::TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [IDX_W-1:0] first_idx,
  input  logic [IDX_W-1:0] num_samples,
  output logic             mlp_start,
  output logic [IDX_W-1:0] mlp_index,
  input  logic             mlp_done,
  input  logic [CLS_W-1:0] mlp_max,
  output logic [IDX_W-1:0] lbl_addr,
  input  logic [CLS_W-1:0] lbl_data,
  output logic             res_valid,
  output logic [IDX_W-1:0] res_index,
  output logic [CLS_W-1:0] res_class,
  output logic             res_correct,
  output logic [IDX_W-1:0] correct_cnt,
  output logic             busy,
  output logic             batch_done,
  output logic             error
);

  import mlp_pkg::*;

  state_t           state_r;
  state_t           next_state_s;

  logic [IDX_W-1:0] idx_r,  idx_s;
  logic [IDX_W-1:0] rem_r,  rem_s;
  logic             done_q_r, done_q_s;
  logic             go_acc_s;
  logic             done_edge_s;
  logic             wd_clr_s, wd_en_s, wd_tc_s;

  logic             mlp_start_r,   mlp_start_s;
  logic             res_valid_r,   res_valid_s;
  logic [IDX_W-1:0] res_index_r,   res_index_s;
  logic [CLS_W-1:0] res_class_r,   res_class_s;
  logic             res_correct_r, res_correct_s;
  logic [IDX_W-1:0] cnt_r,         cnt_s;
  logic             busy_r,        busy_s;
  logic             batch_done_r,  batch_done_s;
  logic             error_r,       error_s;

  assign go_acc_s    = (state_r == S_IDLE) && go;
  // Only a fresh rising edge counts; done_q is zeroed at launch so a level
  // still high from the previous sample cannot be mistaken for completion.
  assign done_edge_s = mlp_done && !done_q_r;
  assign wd_clr_s    = (state_r == S_LAUNCH);
  assign wd_en_s     = (state_r == S_WAIT);

  mlp_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wd_clr_s),
    .en    (wd_en_s),
    .tc    (wd_tc_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode for the batch FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!go) begin
          next_state_s = S_IDLE;
        end else if (num_samples == {IDX_W{1'b0}}) begin
          next_state_s = S_FIN;
        end else begin
          next_state_s = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        next_state_s = S_WAIT;
      end
      S_WAIT: begin
        if (done_edge_s) begin
          next_state_s = S_CAPTURE;
        end else if (wd_tc_s) begin
          next_state_s = S_ERR;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_CAPTURE: begin
        if (rem_r == IDX_W'(1)) begin
          next_state_s = S_FIN;
        end else begin
          next_state_s = S_LAUNCH;
        end
      end
      S_FIN:   next_state_s = S_IDLE;
      S_ERR:   next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Output and datapath next values; every output is registered from these
  // so that each pulse is high exactly during its corresponding state.
  always_comb begin
    idx_s         = idx_r;
    rem_s         = rem_r;
    done_q_s      = mlp_done;
    res_valid_s   = 1'b0;
    res_index_s   = res_index_r;
    res_class_s   = res_class_r;
    res_correct_s = res_correct_r;
    cnt_s         = cnt_r;
    error_s       = error_r;

    if (go_acc_s) begin
      idx_s    = first_idx;
      rem_s    = num_samples;
      done_q_s = 1'b0;
      cnt_s    = {IDX_W{1'b0}};
      error_s  = 1'b0;
    end else if (state_r == S_LAUNCH) begin
      done_q_s = 1'b0;
    end else if ((state_r == S_WAIT) && done_edge_s) begin
      // mlp_max is valid on the rising edge of done; lbl_data has been
      // addressed since launch, so both can be sampled now.
      res_valid_s   = 1'b1;
      res_index_s   = idx_r;
      res_class_s   = mlp_max;
      res_correct_s = (mlp_max == lbl_data);
    end else if ((state_r == S_WAIT) && wd_tc_s) begin
      error_s = 1'b1;
    end else if (state_r == S_CAPTURE) begin
      cnt_s = cnt_r + {{(IDX_W-1){1'b0}}, res_correct_r};
      if (next_state_s == S_LAUNCH) begin
        idx_s = idx_r + IDX_W'(1);
        rem_s = rem_r - IDX_W'(1);
      end else begin
        idx_s = idx_r;
        rem_s = rem_r;
      end
    end else begin
      idx_s = idx_r;
    end

    mlp_start_s  = (next_state_s == S_LAUNCH);
    batch_done_s = (next_state_s == S_FIN);
    busy_s       = is_active(next_state_s);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r         <= {IDX_W{1'b0}};
      rem_r         <= {IDX_W{1'b0}};
      done_q_r      <= 1'b0;
      mlp_start_r   <= 1'b0;
      res_valid_r   <= 1'b0;
      res_index_r   <= {IDX_W{1'b0}};
      res_class_r   <= {CLS_W{1'b0}};
      res_correct_r <= 1'b0;
      cnt_r         <= {IDX_W{1'b0}};
      busy_r        <= 1'b0;
      batch_done_r  <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      idx_r         <= idx_s;
      rem_r         <= rem_s;
      done_q_r      <= done_q_s;
      mlp_start_r   <= mlp_start_s;
      res_valid_r   <= res_valid_s;
      res_index_r   <= res_index_s;
      res_class_r   <= res_class_s;
      res_correct_r <= res_correct_s;
      cnt_r         <= cnt_s;
      busy_r        <= busy_s;
      batch_done_r  <= batch_done_s;
      error_r       <= error_s;
    end
  end

  assign mlp_start   = mlp_start_r;
  assign mlp_index   = idx_r;
  assign lbl_addr    = idx_r;
  assign res_valid   = res_valid_r;
  assign res_index   = res_index_r;
  assign res_class   = res_class_r;
  assign res_correct = res_correct_r;
  assign correct_cnt = cnt_r;
  assign busy        = busy_r;
  assign batch_done  = batch_done_r;
  assign error       = error_r;

endmodule

// File: tb/tb_mlp_batch_sequencer.sv
// Directed bench for mlp_batch_sequencer with a behavioural MLP (programmable
// latency, optional hang, done held high until the next start) and a label ROM.
module tb_mlp_batch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       go;
  logic [9:0] first_idx;
  logic [9:0] num_samples;
  logic       mlp_start;
  logic [9:0] mlp_index;
  logic       mlp_done;
  logic [9:0] mlp_max;
  logic [9:0] lbl_addr;
  logic [9:0] lbl_data;
  logic       res_valid;
  logic [9:0] res_index;
  logic [9:0] res_class;
  logic       res_correct;
  logic [9:0] correct_cnt;
  logic       busy;
  logic       batch_done;
  logic       error;

  mlp_batch_sequencer #(.TIMEOUT(50)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .first_idx(first_idx),
    .num_samples(num_samples), .mlp_start(mlp_start), .mlp_index(mlp_index),
    .mlp_done(mlp_done), .mlp_max(mlp_max), .lbl_addr(lbl_addr),
    .lbl_data(lbl_data), .res_valid(res_valid), .res_index(res_index),
    .res_class(res_class), .res_correct(res_correct),
    .correct_cnt(correct_cnt), .busy(busy), .batch_done(batch_done),
    .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          lat = 20;
  bit          hang = 1'b0;
  logic [15:0] match_sel = 16'h0000;

  function automatic logic [9:0] onehot(input int k);
    logic [9:0] v;
    v = 10'd0;
    v[k % 10] = 1'b1;
    return v;
  endfunction

  function automatic logic [9:0] pred(input logic [9:0] i);
    return match_sel[int'(i) % 16] ? onehot(int'(i)) : onehot(int'(i) + 1);
  endfunction

  // Behavioural MLP core.
  int         mcnt;
  bit         mact;
  logic [9:0] midx;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mlp_done <= 1'b0; mlp_max <= 10'd0; mcnt <= 0; mact <= 1'b0; midx <= 10'd0;
    end else if (mlp_start) begin
      mlp_done <= 1'b0; mact <= 1'b1; mcnt <= lat; midx <= mlp_index;
    end else if (mact && !hang) begin
      if (mcnt <= 1) begin
        mlp_done <= 1'b1; mact <= 1'b0; mlp_max <= pred(midx);
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  // Label ROM, one cycle read latency.
  always @(posedge clk) lbl_data <= onehot(int'(lbl_addr));

  // Event monitor on the falling edge.
  int         tot_res = 0, tot_done = 0, tot_start = 0;
  logic [9:0] log_idx [0:63];
  logic [9:0] log_cls [0:63];
  logic       log_cor [0:63];
  always @(negedge clk) begin
    if (res_valid) begin
      log_idx[tot_res % 64] = res_index;
      log_cls[tot_res % 64] = res_class;
      log_cor[tot_res % 64] = res_correct;
      tot_res = tot_res + 1;
    end
    if (batch_done) tot_done = tot_done + 1;
    if (mlp_start) tot_start = tot_start + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [9:0] f, input logic [9:0] n);
    first_idx = f; num_samples = n; go = 1'b1;
    tick(1);
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base, input int budget);
    int n;
    n = 0;
    while (tot_done == base && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, (tot_done != base), 1'b1);
  endtask

  int b_res, b_done, b_start, n, busy_seen;

  initial begin
    rst_n = 1'b0; go = 1'b0; first_idx = 10'd0; num_samples = 10'd0;
    tick(2);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", mlp_start, 1'b0);
    chk("rst_index", mlp_index, 10'd0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_cnt", correct_cnt, 10'd0);
    chk("rst_error", error, 1'b0);
    chk("rst_batch_done", batch_done, 1'b0);
    rst_n = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (busy) busy_seen++;
    end
    chk("idle_busy_cycles", busy_seen, 0);
    chk("idle_no_start", tot_start, 0);

    // Batch 0..3, latency 20, predictions correct for idx 0 and 2.
    lat = 20; match_sel = 16'h0005;
    b_res = tot_res; b_done = tot_done; b_start = tot_start;
    launch(10'd0, 10'd4);
    chk("b1_start_pulse", mlp_start, 1'b1);
    chk("b1_busy", busy, 1'b1);
    chk("b1_first_index", mlp_index, 10'd0);
    wait_done("b1_done_seen", b_done, 600);
    chk("b1_res_count", tot_res - b_res, 4);
    chk("b1_idx0", log_idx[(b_res + 0) % 64], 10'd0);
    chk("b1_idx1", log_idx[(b_res + 1) % 64], 10'd1);
    chk("b1_idx2", log_idx[(b_res + 2) % 64], 10'd2);
    chk("b1_idx3", log_idx[(b_res + 3) % 64], 10'd3);
    chk("b1_cor0", log_cor[(b_res + 0) % 64], 1'b1);
    chk("b1_cor1", log_cor[(b_res + 1) % 64], 1'b0);
    chk("b1_cls1", log_cls[(b_res + 1) % 64], 10'h004);
    chk("b1_correct_cnt", correct_cnt, 10'd2);
    chk("b1_busy_after", busy, 1'b0);
    chk("b1_res_hold_idx", res_index, 10'd3);
    chk("b1_res_hold_cls", res_class, 10'h010);
    tick(5);
    chk("b1_one_done", tot_done - b_done, 1);
    chk("b1_starts", tot_start - b_start, 4);

    // Empty batch: completes at once, no MLP traffic (stale done still high).
    b_res = tot_res; b_done = tot_done; b_start = tot_start;
    launch(10'd5, 10'd0);
    chk("zero_done_pulse", batch_done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_cnt_cleared", correct_cnt, 10'd0);
    tick(1);
    chk("zero_done_one_cycle", batch_done, 1'b0);
    tick(5);
    chk("zero_no_start", tot_start - b_start, 0);
    chk("zero_no_res", tot_res - b_res, 0);
    chk("zero_one_done", tot_done - b_done, 1);

    // Index wrap 1022, 1023, 0.
    match_sel = 16'hFFFF;
    b_res = tot_res; b_done = tot_done;
    launch(10'd1022, 10'd3);
    wait_done("wrap_done_seen", b_done, 600);
    chk("wrap_res_count", tot_res - b_res, 3);
    chk("wrap_idx0", log_idx[(b_res + 0) % 64], 10'd1022);
    chk("wrap_idx1", log_idx[(b_res + 1) % 64], 10'd1023);
    chk("wrap_idx2", log_idx[(b_res + 2) % 64], 10'd0);
    chk("wrap_correct_cnt", correct_cnt, 10'd3);

    // Watchdog: MLP never completes.
    hang = 1'b1;
    b_res = tot_res; b_done = tot_done;
    launch(10'd5, 10'd2);
    n = 0;
    while (!error && n < 200) begin
      tick(1);
      n++;
    end
    chk("to_error_set", error, 1'b1);
    chk("to_latency_ok", (n >= 48 && n <= 56), 1'b1);
    chk("to_busy", busy, 1'b0);
    chk("to_no_done", tot_done - b_done, 0);
    chk("to_no_res", tot_res - b_res, 0);
    tick(5);
    chk("to_error_sticky", error, 1'b1);
    hang = 1'b0; lat = 3;
    b_done = tot_done;
    launch(10'd5, 10'd1);
    chk("to_error_cleared", error, 1'b0);
    wait_done("to_recover_done", b_done, 200);
    chk("to_recover_cnt", correct_cnt, 10'd1);

    // Level-held done with go pulsed while busy.
    lat = 5;
    b_res = tot_res; b_done = tot_done; b_start = tot_start;
    launch(10'd100, 10'd2);
    tick(3);
    first_idx = 10'd7; num_samples = 10'd9; go = 1'b1;
    tick(3);
    go = 1'b0;
    wait_done("lvl_done_seen", b_done, 300);
    tick(30);
    chk("lvl_res_count", tot_res - b_res, 2);
    chk("lvl_idx0", log_idx[(b_res + 0) % 64], 10'd100);
    chk("lvl_idx1", log_idx[(b_res + 1) % 64], 10'd101);
    chk("lvl_starts", tot_start - b_start, 2);
    chk("lvl_one_done", tot_done - b_done, 1);

    // Reset while waiting on the MLP.
    hang = 1'b1;
    b_res = tot_res; b_done = tot_done;
    launch(10'd200, 10'd3);
    tick(10);
    chk("mid_rst_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    tick(2);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_index", mlp_index, 10'd0);
    chk("mid_rst_cnt", correct_cnt, 10'd0);
    rst_n = 1'b1;
    tick(60);
    chk("mid_rst_no_error", error, 1'b0);
    chk("mid_rst_idle", busy, 1'b0);
    chk("mid_rst_no_done", tot_done - b_done, 0);
    chk("mid_rst_no_res", tot_res - b_res, 0);
    hang = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
